riscv_v_vset_ctrl: RTL and testbench

Sequencer that owns all writes into the vector CSR file (vtype, vl, vstart, vxrm, vxsat). It executes vsetvl/vsetvli/vsetivli: it decodes the requested vtype, computes VLMAX, clamps AVL and commits the vtype/vl/vstart write-enables. It also arbitrates scalar CSR-instruction writes and datapath saturation events onto the same CSR write ports. It sits between the vector decode stage and the vector CSR register block.

---
 rtl/riscv_v_vset_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_riscv_v_vset_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_vset_ctrl.sv
// Sequencer for vsetvl/vsetvli/vsetivli plus arbiter for scalar CSR and saturation writes into
// the vector CSR file. Define RISCV_V_FRAC_LMUL_EN to support fractional LMUL (vlmul 101/110/111).
module riscv_v_vset_ctrl #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            vset_valid_i,
  output logic            vset_ready_o,
  input  logic [XLEN-1:0] vset_avl_i,
  input  logic [XLEN-1:0] vset_vtype_i,
  input  logic            vset_max_vl_i,
  input  logic            vset_keep_vl_i,
  input  logic [XLEN-1:0] vl_cur_i,
  output logic            vset_done_o,
  output logic [XLEN-1:0] vset_rd_data_o,
  input  logic            csr_wr_valid_i,
  output logic            csr_wr_ready_o,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            sat_set_i,
  output logic            vtype_wr_en_o,
  output logic            vl_wr_en_o,
  output logic            vstart_wr_en_o,
  output logic            vxrm_wr_en_o,
  output logic            vxsat_wr_en_o,
  output logic [XLEN-1:0] vtype_data_o,
  output logic [XLEN-1:0] vl_data_o,
  output logic [XLEN-1:0] vstart_data_o,
  output logic [1:0]      vxrm_data_o,
  output logic            vxsat_data_o
);

  localparam int VlenLog2 = $clog2(VLEN);
  localparam int ElenLog2 = $clog2(ELEN);

  typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_e;

  state_e          state_q;
  logic [XLEN-1:0] avl_q, vl_cur_q;
  logic [XLEN-2:0] vtype_q;  // vtype bit XLEN-1 is not part of the request
  logic            max_vl_q, keep_vl_q;

  logic            vtype_wr_en_q, vl_wr_en_q, vstart_wr_en_q, vxrm_wr_en_q, vxsat_wr_en_q;
  logic            vset_done_q;
  logic [XLEN-1:0] vtype_data_q, vl_data_q, vstart_data_q, vset_rd_data_q;
  logic [1:0]      vxrm_data_q;
  logic            vxsat_data_q;

  logic [2:0]      vlmul, vsew;
  logic            frac, vill;
  int              sew_log2, lmul_log2, vlmax_log2;
  logic [XLEN-1:0] vlmax, vl_new, vtype_new;
  logic            csr_acc, csr_vxsat_hit;

  always_comb begin
    vlmul      = vtype_q[2:0];
    vsew       = vtype_q[5:3];
    frac       = vlmul[2] && (vlmul != 3'b100);
    sew_log2   = 3 + int'(vsew);
    lmul_log2  = frac ? int'(vlmul) - 8 : int'(vlmul);
    vlmax_log2 = VlenLog2 - sew_log2 + lmul_log2;

    vill = 1'b0;
    if (vsew[2])                                     vill = 1'b1;
    if (sew_log2 > ElenLog2)                         vill = 1'b1;
    if (vlmul == 3'b100)                             vill = 1'b1;
    if (|vtype_q[XLEN-2:8])                          vill = 1'b1;
    if (vlmax_log2 < 0)                              vill = 1'b1;
    if (frac && (sew_log2 > ElenLog2 + lmul_log2))   vill = 1'b1;
`ifndef RISCV_V_FRAC_LMUL_EN
    if (frac)                                        vill = 1'b1;
`endif

    vlmax = '0;
    if (!vill) vlmax = XLEN'(1) << vlmax_log2[4:0];

    if (vill)           vl_new = '0;
    else if (max_vl_q)  vl_new = vlmax;
    else if (keep_vl_q) vl_new = (vl_cur_q < vlmax) ? vl_cur_q : vlmax;
    else                vl_new = (avl_q < vlmax) ? avl_q : vlmax;

    vtype_new = vill ? {1'b1, {(XLEN-1){1'b0}}} : {{(XLEN-8){1'b0}}, vtype_q[7:0]};
  end

  // vset requests win over scalar CSR writes for the shared write ports.
  assign csr_wr_ready_o = (state_q == StIdle) && !vset_valid_i;
  assign csr_acc        = csr_wr_valid_i && csr_wr_ready_o;
  assign csr_vxsat_hit  = csr_acc && ((csr_addr_i == 12'h009) || (csr_addr_i == 12'h00F));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      avl_q          <= '0;
      vtype_q        <= '0;
      vl_cur_q       <= '0;
      max_vl_q       <= 1'b0;
      keep_vl_q      <= 1'b0;
      vtype_wr_en_q  <= 1'b0;
      vl_wr_en_q     <= 1'b0;
      vstart_wr_en_q <= 1'b0;
      vxrm_wr_en_q   <= 1'b0;
      vxsat_wr_en_q  <= 1'b0;
      vset_done_q    <= 1'b0;
      vtype_data_q   <= '0;
      vl_data_q      <= '0;
      vstart_data_q  <= '0;
      vset_rd_data_q <= '0;
      vxrm_data_q    <= '0;
      vxsat_data_q   <= 1'b0;
    end else begin
      vtype_wr_en_q  <= 1'b0;
      vl_wr_en_q     <= 1'b0;
      vstart_wr_en_q <= 1'b0;
      vxrm_wr_en_q   <= 1'b0;
      vxsat_wr_en_q  <= 1'b0;
      vset_done_q    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (vset_valid_i) begin
            avl_q     <= vset_avl_i;
            vtype_q   <= vset_vtype_i[XLEN-2:0];
            vl_cur_q  <= vl_cur_i;
            max_vl_q  <= vset_max_vl_i;
            keep_vl_q <= vset_keep_vl_i;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          state_q        <= StCommit;
          vtype_wr_en_q  <= 1'b1;
          vl_wr_en_q     <= 1'b1;
          vstart_wr_en_q <= 1'b1;
          vset_done_q    <= 1'b1;
          vtype_data_q   <= vtype_new;
          vl_data_q      <= vl_new;
          vstart_data_q  <= '0;
          vset_rd_data_q <= vl_new;
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase

      if (csr_acc) begin
        case (csr_addr_i)
          12'h008: begin
            vstart_wr_en_q <= 1'b1;
            vstart_data_q  <= csr_wdata_i;
          end
          12'h00A, 12'h00F: begin
            vxrm_wr_en_q <= 1'b1;
            vxrm_data_q  <= (csr_addr_i == 12'h00A) ? csr_wdata_i[1:0] : csr_wdata_i[2:1];
          end
          default: ;
        endcase
      end

      if (sat_set_i || csr_vxsat_hit) begin
        vxsat_wr_en_q <= 1'b1;
        vxsat_data_q  <= csr_vxsat_hit ? csr_wdata_i[0] : 1'b1;
      end
    end
  end

  assign vset_ready_o   = (state_q == StIdle);
  assign vset_done_o    = vset_done_q;
  assign vset_rd_data_o = vset_rd_data_q;
  assign vtype_wr_en_o  = vtype_wr_en_q;
  assign vl_wr_en_o     = vl_wr_en_q;
  assign vstart_wr_en_o = vstart_wr_en_q;
  assign vxrm_wr_en_o   = vxrm_wr_en_q;
  assign vxsat_wr_en_o  = vxsat_wr_en_q;
  assign vtype_data_o   = vtype_data_q;
  assign vl_data_o      = vl_data_q;
  assign vstart_data_o  = vstart_data_q;
  assign vxrm_data_o    = vxrm_data_q;
  assign vxsat_data_o   = vxsat_data_q;

endmodule

// File: tb/tb_riscv_v_vset_ctrl.sv
// Scoreboard bench for riscv_v_vset_ctrl (VLEN=128, ELEN=32, XLEN=32).
module tb_riscv_v_vset_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vset_valid, vset_ready, vset_max_vl, vset_keep_vl, vset_done;
  logic [31:0] vset_avl, vset_vtype, vl_cur, vset_rd_data;
  logic        csr_wr_valid, csr_wr_ready, sat_set;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        vtype_wr_en, vl_wr_en, vstart_wr_en, vxrm_wr_en, vxsat_wr_en;
  logic [31:0] vtype_data, vl_data, vstart_data;
  logic [1:0]  vxrm_data;
  logic        vxsat_data;

  riscv_v_vset_ctrl #(.VLEN(128), .ELEN(32), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .vset_valid_i   (vset_valid),
    .vset_ready_o   (vset_ready),
    .vset_avl_i     (vset_avl),
    .vset_vtype_i   (vset_vtype),
    .vset_max_vl_i  (vset_max_vl),
    .vset_keep_vl_i (vset_keep_vl),
    .vl_cur_i       (vl_cur),
    .vset_done_o    (vset_done),
    .vset_rd_data_o (vset_rd_data),
    .csr_wr_valid_i (csr_wr_valid),
    .csr_wr_ready_o (csr_wr_ready),
    .csr_addr_i     (csr_addr),
    .csr_wdata_i    (csr_wdata),
    .sat_set_i      (sat_set),
    .vtype_wr_en_o  (vtype_wr_en),
    .vl_wr_en_o     (vl_wr_en),
    .vstart_wr_en_o (vstart_wr_en),
    .vxrm_wr_en_o   (vxrm_wr_en),
    .vxsat_wr_en_o  (vxsat_wr_en),
    .vtype_data_o   (vtype_data),
    .vl_data_o      (vl_data),
    .vstart_data_o  (vstart_data),
    .vxrm_data_o    (vxrm_data),
    .vxsat_data_o   (vxsat_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // en = {done, vtype, vl, vstart, vxrm, vxsat}
  typedef struct {
    int          cyc;
    logic [5:0]  en;
    logic [31:0] vtype;
    logic [31:0] vl;
    logic [31:0] vstart;
    logic [1:0]  vxrm;
    logic        vxsat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_vset(input int c, input logic [31:0] t, input logic [31:0] l);
    exp_t e;
    e.cyc = c; e.en = 6'b111100; e.vtype = t; e.vl = l; e.vstart = '0;
    e.vxrm = '0; e.vxsat = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_csr(input int c, input logic [2:0] en, input logic [31:0] vs,
                                  input logic [1:0] rm, input logic sat);
    exp_t e;
    e.cyc = c; e.en = {3'b000, en}; e.vtype = '0; e.vl = '0; e.vstart = vs;
    e.vxrm = rm; e.vxsat = sat;
    return e;
  endfunction

  // Monitor: every cycle with an enable or done must match the head of the scoreboard.
  logic [5:0] mon_en;
  exp_t       mon_e;
  always @(negedge clk) begin
    mon_en = {vset_done, vtype_wr_en, vl_wr_en, vstart_wr_en, vxrm_wr_en, vxsat_wr_en};
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL missing_event: got none expected en=%b at cycle %0d",
               sb_q[0].en, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (mon_en != 6'b0) begin
      if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_event: got en=%b expected none (cycle %0d)", mon_en, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("enables", {26'b0, mon_en}, {26'b0, mon_e.en});
        if (mon_e.en[5]) begin
          check("vtype_data", vtype_data, mon_e.vtype);
          check("vl_data", vl_data, mon_e.vl);
          check("vset_rd_data", vset_rd_data, mon_e.vl);
        end
        if (mon_e.en[2]) check("vstart_data", vstart_data, mon_e.vstart);
        if (mon_e.en[1]) check("vxrm_data", {30'b0, vxrm_data}, {30'b0, mon_e.vxrm});
        if (mon_e.en[0]) check("vxsat_data", {31'b0, vxsat_data}, {31'b0, mon_e.vxsat});
      end
    end
  end

  task automatic do_vset(input logic [31:0] avl, input logic [31:0] vt, input logic mx,
                         input logic kp, input logic [31:0] cur,
                         input logic [31:0] e_vtype, input logic [31:0] e_vl);
    int n = 0;
    while (!vset_ready && n < 8) begin @(negedge clk); n++; end
    if (!vset_ready) begin
      check("vset_ready_timeout", {31'b0, vset_ready}, 32'd1);
    end else begin
      vset_valid = 1'b1; vset_avl = avl; vset_vtype = vt;
      vset_max_vl = mx; vset_keep_vl = kp; vl_cur = cur;
      sb_q.push_back(mk_vset(cyc + 2, e_vtype, e_vl));
      @(negedge clk);
      vset_valid = 1'b0; vset_max_vl = 1'b0; vset_keep_vl = 1'b0;
    end
  endtask

  task automatic do_csr(input logic [11:0] a, input logic [31:0] d, input logic sat,
                        input logic [2:0] e_en, input logic [31:0] e_vs,
                        input logic [1:0] e_rm, input logic e_sat);
    int n = 0;
    csr_wr_valid = 1'b1; csr_addr = a; csr_wdata = d; sat_set = sat;
    #1;
    while (!csr_wr_ready && n < 8) begin @(negedge clk); #1; n++; end
    if (!csr_wr_ready) check("csr_ready_timeout", {31'b0, csr_wr_ready}, 32'd1);
    else if (e_en != 3'b0) sb_q.push_back(mk_csr(cyc + 1, e_en, e_vs, e_rm, e_sat));
    @(negedge clk);
    csr_wr_valid = 1'b0; sat_set = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    vset_valid = 1'b0; vset_avl = '0; vset_vtype = '0; vset_max_vl = 1'b0;
    vset_keep_vl = 1'b0; vl_cur = '0;
    csr_wr_valid = 1'b0; csr_addr = '0; csr_wdata = '0; sat_set = 1'b0;

    @(negedge clk);
    check("rst_vset_ready", {31'b0, vset_ready}, 32'd1);
    check("rst_csr_ready", {31'b0, csr_wr_ready}, 32'd1);
    check("rst_enables", {26'b0, vset_done, vtype_wr_en, vl_wr_en, vstart_wr_en, vxrm_wr_en,
                          vxsat_wr_en}, 32'd0);
    check("rst_data", vtype_data | vl_data | vstart_data | vset_rd_data
                      | {29'b0, vxrm_data, vxsat_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_vset(32'd10, 32'h10, 1'b0, 1'b0, 32'd0, 32'h10, 32'd4);           // clamp
    do_vset(32'd3, 32'h01, 1'b0, 1'b0, 32'd0, 32'h01, 32'd3);            // short avl
    do_vset(32'd10, 32'h18, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd0);    // sew64
    do_vset(32'd10, 32'h04, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd0);    // vlmul 100
    do_vset(32'd10, 32'h100, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd0);   // reserved bit
    do_vset(32'd5, 32'h0A, 1'b1, 1'b0, 32'd0, 32'h0A, 32'd32);           // max_vl
    do_vset(32'd5, 32'h0A, 1'b0, 1'b1, 32'd40, 32'h0A, 32'd32);          // keep, clamp
    do_vset(32'd99, 32'h0A, 1'b0, 1'b1, 32'd7, 32'h0A, 32'd7);           // keep, pass
    do_vset(32'd100, 32'hD1, 1'b0, 1'b0, 32'd0, 32'hD1, 32'd8);          // vta/vma
`ifdef RISCV_V_FRAC_LMUL_EN
    do_vset(32'd20, 32'h07, 1'b0, 1'b0, 32'd0, 32'h07, 32'd8);
`else
    do_vset(32'd20, 32'h07, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd0);
`endif
    do_vset(32'd20, 32'h17, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd0);    // sew > ELEN*LMUL

    do_csr(12'h008, 32'h33, 1'b0, 3'b100, 32'h33, 2'd0, 1'b0);
    do_csr(12'h00A, 32'h3, 1'b0, 3'b010, 32'd0, 2'd3, 1'b0);
    do_csr(12'h009, 32'h1, 1'b0, 3'b001, 32'd0, 2'd0, 1'b1);
    do_csr(12'h123, 32'hFF, 1'b0, 3'b000, 32'd0, 2'd0, 1'b0);            // dropped
    do_csr(12'h009, 32'h0, 1'b1, 3'b001, 32'd0, 2'd0, 1'b0);             // csr beats sat
    sat_set = 1'b1;
    sb_q.push_back(mk_csr(cyc + 1, 3'b001, 32'd0, 2'd0, 1'b1));
    @(negedge clk);
    sat_set = 1'b0;
    @(negedge clk);

    // Arbitration: vset and vcsr write offered together.
    vset_valid = 1'b1; vset_avl = 32'd10; vset_vtype = 32'h10;
    csr_wr_valid = 1'b1; csr_addr = 12'h00F; csr_wdata = 32'h5;
    sb_q.push_back(mk_vset(cyc + 2, 32'h10, 32'd4));
    #1 check("arb_csr_ready_t0", {31'b0, csr_wr_ready}, 32'd0);
    @(negedge clk);
    vset_valid = 1'b0;
    #1 check("arb_csr_ready_t1", {31'b0, csr_wr_ready}, 32'd0);
    check("arb_vset_ready_t1", {31'b0, vset_ready}, 32'd0);
    @(negedge clk);
    #1 check("arb_csr_ready_t2", {31'b0, csr_wr_ready}, 32'd0);
    check("arb_vset_ready_t2", {31'b0, vset_ready}, 32'd0);
    @(negedge clk);
    #1 check("arb_csr_ready_t3", {31'b0, csr_wr_ready}, 32'd1);
    check("arb_vset_ready_t3", {31'b0, vset_ready}, 32'd1);
    sb_q.push_back(mk_csr(cyc + 1, 3'b011, 32'd0, 2'd2, 1'b1));
    @(negedge clk);
    csr_wr_valid = 1'b0;
    @(negedge clk);

    // Saturation during CALC lands in the commit cycle.
    vset_valid = 1'b1; vset_avl = 32'd3; vset_vtype = 32'h01;
    e = mk_vset(cyc + 2, 32'h01, 32'd3);
    e.en[0] = 1'b1; e.vxsat = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    vset_valid = 1'b0; sat_set = 1'b1;
    @(negedge clk);
    sat_set = 1'b0;
    @(negedge clk);

    // Reset during CALC aborts the request silently.
    vset_valid = 1'b1; vset_avl = 32'd10; vset_vtype = 32'h10;
    @(negedge clk);
    vset_valid = 1'b0;
    check("abort_in_calc", {31'b0, vset_ready}, 32'd0);
    rst = 1'b1;
    #1 check("abort_vset_ready", {31'b0, vset_ready}, 32'd1);
    check("abort_data", vl_data | vtype_data | vset_rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_idle", {31'b0, vset_ready}, 32'd1);

    do_vset(32'd10, 32'h10, 1'b0, 1'b0, 32'd0, 32'h10, 32'd4);           // recovery

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
